if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline; sits directly upstream of the instruction memory and feeds the decode stage.
- Owns the program counter and drives the PC as the byte address into instruction memory.
- Takes the combinational instruction word returned by memory and registers it, with PC+4, into the IF/ID pipeline register.
- Handles decode-stage stall, EX-stage branch/jump redirect, and flush, and keeps simple performance counters.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID as a bubble (sll $0,$0,0).
CNT_W, 16, width of the fetch and stall performance counters.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_i  input  1  synchronous reset, active-high.
stall_i  input  1  hazard unit: hold PC and IF/ID contents this cycle.
redirect_i  input  1  EX stage: branch taken or jump; load redirect_pc_i.
redirect_pc_i  input  32  redirect target byte address.
flush_i  input  1  squash the IF/ID entry without changing the PC path.
instr_i  input  32  instruction word from instruction memory; combinational from pc_addr_o.
pc_addr_o  output  32  current PC, byte address, to instruction memory.
if_id_pc4_o  output  32  registered PC+4 of the instruction held in IF/ID.
if_id_instr_o  output  32  registered instruction.
if_id_valid_o  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
fetch_cnt_o  output  CNT_W  number of instructions accepted into IF/ID.
stall_cnt_o  output  CNT_W  number of cycles with stall_i applied while not redirected.

Behaviour:
- Reset (rst_i high at a clock edge) sets the following, and overrides every other input:
  - pc = RESET_PC.
  - if_id_pc4_o = 0, if_id_instr_o = NOP_INSTR, if_id_valid_o = 0.
  - Both counters = 0.
- Reset asserted mid-stream discards any pending redirect or stall.
- pc_addr_o is the PC register output directly. Memory read is combinational, so instr_i is valid in the same cycle and fetch latency is 1 cycle from PC to IF/ID.
- Redirect targets: the low 2 bits of redirect_pc_i are forced to 0 before loading. The PC is always word aligned.
- PC+4 uses 32-bit modular arithmetic: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No error flag.
- Priority per edge, highest first: rst_i > redirect_i > stall_i > flush_i > normal.
  - REDIRECT (redirect_i=1, regardless of stall_i):
    - pc <= aligned redirect_pc_i.
    - IF/ID <= bubble (instr=NOP_INSTR, valid=0, pc4=0).
    - Counters unchanged.
    - The older EX-stage branch wins over a younger decode stall.
  - STALL (stall_i=1, redirect_i=0):
    - pc holds and IF/ID holds all fields.
    - stall_cnt increments.
    - flush_i is ignored while stalled.
  - FLUSH (flush_i=1, stall_i=0, redirect_i=0):
    - pc <= pc+4.
    - IF/ID <= bubble.
    - fetch_cnt unchanged.
  - NORMAL:
    - pc <= pc+4.
    - if_id_instr_o <= instr_i, if_id_pc4_o <= pc+4, if_id_valid_o <= 1.
    - fetch_cnt increments.
- Counters saturate at all-ones; they never wrap.
- No combinational path from any input to pc_addr_o.
- pc_addr_o must remain stable for the whole cycle so the memory output is glitch-free at the edge.

Test Plan:
- Reset then 4 free-running cycles, memory word k = 32'h2000_0000+k:
  - pc_addr_o sequence 0,4,8,12.
  - IF/ID instr 32'h2000_0000..2 with pc4 4,8,12; valid=1.
  - fetch_cnt=3 after cycle 4.
- Stall for 2 cycles at pc=8:
  - pc_addr_o stays 8.
  - IF/ID holds instr for pc=4 (pc4=8).
  - stall_cnt=2.
  - Release resumes at 8 with no skipped or duplicated instruction.
- Redirect to 32'h0000_0043 at pc=16:
  - Next pc_addr_o=32'h0000_0040.
  - IF/ID valid=0, instr=0 for one cycle.
  - The following cycle latches word 16 with pc4=32'h44.
- Redirect and stall in the same cycle:
  - Redirect wins; pc loads target, IF/ID is a bubble.
  - stall_cnt unchanged.
- Flush alone at pc=20:
  - pc advances to 24.
  - IF/ID valid=0.
  - fetch_cnt unchanged.
- Reset asserted during stall with pending redirect:
  - Next cycle pc=RESET_PC, valid=0, both counters 0.
  - Force pc near 32'hFFFF_FFFC via redirect; it wraps to 0 after one normal cycle.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- MIPS instruction-fetch stage.
//
// Owns the program counter, presents it as the byte address to instruction
// memory, and registers the returned instruction word with its PC+4 into the
// IF/ID pipeline register. Handles decode stall, EX redirect (branch/jump)
// and flush, and keeps saturating fetch/stall performance counters.
//
// Ports
//   clk_i          clock, all state updates on rising edge
//   rst_i          synchronous reset, active-high
//   stall_i        hold PC and IF/ID this cycle
//   redirect_i     load redirect_pc_i into PC, bubble IF/ID
//   redirect_pc_i  redirect target (low two bits ignored)
//   flush_i        bubble IF/ID, PC still advances
//   instr_i        instruction word, combinational from pc_addr_o
//   pc_addr_o      current PC (registered, no input-to-output path)
//   if_id_pc4_o    PC+4 of the instruction held in IF/ID
//   if_id_instr_o  instruction held in IF/ID
//   if_id_valid_o  1 = real instruction, 0 = bubble
//   fetch_cnt_o    instructions accepted into IF/ID (saturating)
//   stall_cnt_o    stalled, non-redirected cycles (saturating)
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    input  logic             flush_i,
    input  logic [31:0]      instr_i,
    output logic [31:0]      pc_addr_o,
    output logic [31:0]      if_id_pc4_o,
    output logic [31:0]      if_id_instr_o,
    output logic             if_id_valid_o,
    output logic [CNT_W-1:0] fetch_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    // Reset value is forced word aligned even if the parameter is misset.
    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};
    localparam if_id_t      BUBBLE      = '{pc4: 32'd0, instr: NOP_INSTR, valid: 1'b0};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc_plus4;
    logic [31:0]      redir_pc;
    if_id_t           if_id_q, if_id_d;
    logic             fetch_inc, stall_inc;
    logic [CNT_W-1:0] fetch_cnt_q, stall_cnt_q;

    // PC+4 wraps modulo 2^32 by construction of the 32-bit add.
    assign pc_plus4 = pc_q + 32'd4;
    assign redir_pc = {redirect_pc_i[31:2], 2'b00};

    // Next-state selection, priority redirect > stall > flush > normal.
    // Redirect beats stall: the branch in EX is older than the instruction
    // stalling in decode, so the stalled instruction is on the wrong path.
    always_comb begin
        pc_d      = pc_q;
        if_id_d   = if_id_q;
        fetch_inc = 1'b0;
        stall_inc = 1'b0;
        if (redirect_i) begin
            pc_d    = redir_pc;
            if_id_d = BUBBLE;
        end else if (stall_i) begin
            // flush_i is deliberately ignored here: the held entry is still
            // needed by decode once the stall releases.
            stall_inc = 1'b1;
        end else if (flush_i) begin
            pc_d    = pc_plus4;
            if_id_d = BUBBLE;
        end else begin
            pc_d      = pc_plus4;
            if_id_d   = '{pc4: pc_plus4, instr: instr_i, valid: 1'b1};
            fetch_inc = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= RESET_PC_AL;
            if_id_q <= BUBBLE;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end

    // Saturating counters: stop at all-ones rather than wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fetch_inc && (fetch_cnt_q != '1))
                fetch_cnt_q <= fetch_cnt_q + CNT_ONE;
            if (stall_inc && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
        end
    end

    // PC goes straight from the flop to memory so the address is stable for
    // the whole cycle.
    assign pc_addr_o     = pc_q;
    assign if_id_pc4_o   = if_id_q.pc4;
    assign if_id_instr_o = if_id_q.instr;
    assign if_id_valid_o = if_id_q.valid;
    assign fetch_cnt_o   = fetch_cnt_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule
